random_access_queue: RTL

Multi-port, out-of-order entry buffer that owns the storage and valid state serviced by the team's static-priority slot selection logic. Each cycle it allocates the lowest-index free entries to up to EnqWidth writers, and offers the lowest-index eligible valid entries to up to DeqWidth readers. Entries may retire in any order. It sits between a producer (e.g. NoC ingress or request tracker) and a consumer that wakes entries selectively (issue/arbitration stage).

---
 rtl/random_access_queue_pkg.sv | 23 ++
 rtl/random_access_queue_if.sv | 36 +++
 rtl/rand_queue_nth_picker.sv | 28 ++
 rtl/random_access_queue.sv | 99 +++++++++
 4 files changed

// File: rtl/random_access_queue_pkg.sv
// Shared helpers for the random-access queue: bit counting, width sizing and
// lowest-set-bit isolation over a fixed-width mask.
package random_access_queue_pkg;

  localparam int MaxDepth = 64;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned popcount(input logic [MaxDepth-1:0] m);
    int unsigned c;
    c = 0;
    for (int k = 0; k < MaxDepth; k++) c += 32'(m[k]);
    return c;
  endfunction

  // Two's-complement trick: m & -m keeps only the lowest set bit.
  function automatic logic [MaxDepth-1:0] lowest_set(input logic [MaxDepth-1:0] m);
    return m & (~m + MaxDepth'(1));
  endfunction

endpackage

// File: rtl/random_access_queue_if.sv
// Producer/consumer-facing signal bundle for random_access_queue.
interface random_access_queue_if
  import random_access_queue_pkg::*;
#(
  parameter int Depth     = 8,
  parameter int EnqWidth  = 2,
  parameter int DeqWidth  = 2,
  parameter int DataWidth = 32
);
  localparam int IdxWidth = $clog2(Depth);
  localparam int CntWidth = cnt_width(Depth);

  logic                                flush_i;
  logic [EnqWidth-1:0]                 enq_vld_i;
  logic [EnqWidth-1:0][DataWidth-1:0]  enq_data_i;
  logic [EnqWidth-1:0]                 enq_rdy_o;
  logic [EnqWidth-1:0][IdxWidth-1:0]   enq_idx_o;
  logic [Depth-1:0]                    sel_mask_i;
  logic [DeqWidth-1:0]                 deq_vld_o;
  logic [DeqWidth-1:0][DataWidth-1:0]  deq_data_o;
  logic [DeqWidth-1:0][IdxWidth-1:0]   deq_idx_o;
  logic [DeqWidth-1:0]                 deq_rdy_i;
  logic [Depth-1:0]                    entry_vld_o;
  logic [CntWidth-1:0]                 count_o;

  modport slave (
    input  flush_i, enq_vld_i, enq_data_i, sel_mask_i, deq_rdy_i,
    output enq_rdy_o, enq_idx_o, deq_vld_o, deq_data_o, deq_idx_o, entry_vld_o, count_o
  );

  modport master (
    output flush_i, enq_vld_i, enq_data_i, sel_mask_i, deq_rdy_i,
    input  enq_rdy_o, enq_idx_o, deq_vld_o, deq_data_o, deq_idx_o, entry_vld_o, count_o
  );

endinterface

// File: rtl/rand_queue_nth_picker.sv
// Returns one-hot masks of the 1st..Width-th lowest set bits of mask_i,
// with a found flag per port.
module rand_queue_nth_picker
  import random_access_queue_pkg::*;
#(
  parameter int Depth = 8,
  parameter int Width = 2
) (
  input  logic [Depth-1:0]             mask_i,
  output logic [Width-1:0][Depth-1:0]  onehot_o,
  output logic [Width-1:0]             found_o
);

  logic [Depth-1:0] rem;

  // Peel off the lowest remaining bit once per port.
  always_comb begin
    rem      = mask_i;
    onehot_o = '0;
    found_o  = '0;
    for (int w = 0; w < Width; w++) begin
      onehot_o[w] = Depth'(lowest_set(MaxDepth'(rem)));
      found_o[w]  = |rem;
      rem         = rem & ~onehot_o[w];
    end
  end

endmodule

// File: rtl/random_access_queue.sv
// Out-of-order entry buffer: lowest-free allocation for writers, lowest-eligible
// offer for readers, any-order retirement.
module random_access_queue
  import random_access_queue_pkg::*;
#(
  parameter int Depth     = 8,
  parameter int EnqWidth  = 2,
  parameter int DeqWidth  = 2,
  parameter int DataWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  random_access_queue_if.slave  q_if
);

  localparam int IdxWidth = $clog2(Depth);
  localparam int CntWidth = cnt_width(Depth);

  logic [Depth-1:0]                   vld_q, vld_d;
  logic [Depth-1:0][DataWidth-1:0]    data_q, data_d;
  logic [CntWidth-1:0]                count_q, count_d;

  logic [Depth-1:0]                   free_mask, elig_mask;
  logic [EnqWidth-1:0][Depth-1:0]     enq_oh;
  logic [EnqWidth-1:0]                enq_found;
  logic [DeqWidth-1:0][Depth-1:0]     deq_oh;
  logic [DeqWidth-1:0]                deq_found;
  logic [EnqWidth-1:0][IdxWidth-1:0]  enq_idx;
  logic [DeqWidth-1:0][IdxWidth-1:0]  deq_idx;
  logic [DeqWidth-1:0][DataWidth-1:0] deq_data;

  // Masking the picker inputs during reset zeroes every port output at once.
  assign free_mask = rst_ni ? ~vld_q : '0;
  assign elig_mask = rst_ni ? (vld_q & q_if.sel_mask_i) : '0;

  rand_queue_nth_picker #(.Depth(Depth), .Width(EnqWidth)) u_enq_pick (
    .mask_i   (free_mask),
    .onehot_o (enq_oh),
    .found_o  (enq_found)
  );

  rand_queue_nth_picker #(.Depth(Depth), .Width(DeqWidth)) u_deq_pick (
    .mask_i   (elig_mask),
    .onehot_o (deq_oh),
    .found_o  (deq_found)
  );

  always_comb begin
    enq_idx  = '0;
    deq_idx  = '0;
    deq_data = '0;
    for (int i = 0; i < EnqWidth; i++)
      for (int k = 0; k < Depth; k++)
        if (enq_oh[i][k]) enq_idx[i] = IdxWidth'(k);
    for (int j = 0; j < DeqWidth; j++)
      for (int k = 0; k < Depth; k++)
        if (deq_oh[j][k]) begin
          deq_idx[j]  = IdxWidth'(k);
          deq_data[j] = data_q[k];
        end
  end

  assign q_if.enq_rdy_o   = enq_found;
  assign q_if.enq_idx_o   = enq_idx;
  assign q_if.deq_vld_o   = deq_found;
  assign q_if.deq_idx_o   = deq_idx;
  assign q_if.deq_data_o  = deq_data;
  assign q_if.entry_vld_o = vld_q;
  assign q_if.count_o     = count_q;

  // Enq and deq bindings both derive from vld_q, so they never hit the same entry.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    for (int i = 0; i < EnqWidth; i++)
      if (q_if.enq_vld_i[i] && enq_found[i]) begin
        vld_d = vld_d | enq_oh[i];
        for (int k = 0; k < Depth; k++)
          if (enq_oh[i][k]) data_d[k] = q_if.enq_data_i[i];
      end
    for (int j = 0; j < DeqWidth; j++)
      if (deq_found[j] && q_if.deq_rdy_i[j]) vld_d = vld_d & ~deq_oh[j];
    if (q_if.flush_i) vld_d = '0;
    count_d = CntWidth'(popcount(MaxDepth'(vld_d)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) data_q <= data_d;

endmodule
